// File: rtl/hazard_pkg.sv
// Shared types and helpers for the WISC-15 hazard scoreboard.
package hazard_pkg;

    // Widest supported register address; narrower addresses are zero-extended.
    localparam int DST_W  = 8;
    localparam int FWD_RF = 0;

    typedef struct packed {
        logic             v;
        logic [DST_W-1:0] dst;
        logic             load;
    } entry_t;

    function automatic int sel_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/hazard_operand_match.sv
// Per-operand search of the scoreboard: youngest matching stage decides
// between forwarding, stalling or reading the register file.
module hazard_operand_match
    import hazard_pkg::*;
#(
    parameter int AW          = 4,
    parameter int DEPTH       = 3,
    parameter int LOAD_READY  = 2,
    parameter int ZERO_REG_EN = 1,
    parameter int SW          = sel_width(DEPTH)
) (
    input  entry_t [DEPTH:1] ent_i,
    input  logic [AW-1:0]    reg_i,
    input  logic             use_i,
    input  logic             fwd_en_i,
    output logic             op_stall_o,
    output logic [SW-1:0]    fwd_sel_o
);

    logic en;
    logic hit;

    assign en = use_i && !(ZERO_REG_EN != 0 && reg_i == '0);

    always_comb begin
        op_stall_o = 1'b0;
        fwd_sel_o  = SW'(FWD_RF);
        hit        = 1'b0;
        for (int k = 1; k <= DEPTH; k++) begin
            if (!hit && en && ent_i[k].v && ent_i[k].dst == DST_W'(reg_i)) begin
                hit = 1'b1;
                if (!fwd_en_i) begin
                    // The last stage writes the register file before ID reads it.
                    op_stall_o = (k < DEPTH);
                end else if (!ent_i[k].load || k >= LOAD_READY) begin
                    fwd_sel_o = SW'(k);
                end else begin
                    op_stall_o = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard unit beside ID: shift scoreboard of in-flight writes, stall and
// forward-select generation, saturating stall counter.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int AW          = 4,
    parameter int DEPTH       = 3,
    parameter int LOAD_READY  = 2,
    parameter int ZERO_REG_EN = 1,
    parameter int CNTW        = 16,
    parameter int SW          = sel_width(DEPTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [AW-1:0]   id_rd_reg1,
    input  logic [AW-1:0]   id_rd_reg2,
    input  logic            id_use1,
    input  logic            id_use2,
    input  logic            id_wrt,
    input  logic [AW-1:0]   id_dst,
    input  logic            id_is_load,
    input  logic            fwd_en,
    input  logic            flush,
    output logic            stall,
    output logic [SW-1:0]   fwd_sel1,
    output logic [SW-1:0]   fwd_sel2,
    output logic [CNTW-1:0] stall_cnt
);

    entry_t [DEPTH:1] e_q, e_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic             st1, st2;

    hazard_operand_match #(
        .AW(AW), .DEPTH(DEPTH), .LOAD_READY(LOAD_READY),
        .ZERO_REG_EN(ZERO_REG_EN), .SW(SW)
    ) u_op1 (
        .ent_i(e_q), .reg_i(id_rd_reg1), .use_i(id_valid & id_use1),
        .fwd_en_i(fwd_en), .op_stall_o(st1), .fwd_sel_o(fwd_sel1)
    );

    hazard_operand_match #(
        .AW(AW), .DEPTH(DEPTH), .LOAD_READY(LOAD_READY),
        .ZERO_REG_EN(ZERO_REG_EN), .SW(SW)
    ) u_op2 (
        .ent_i(e_q), .reg_i(id_rd_reg2), .use_i(id_valid & id_use2),
        .fwd_en_i(fwd_en), .op_stall_o(st2), .fwd_sel_o(fwd_sel2)
    );

    assign stall     = (st1 | st2) & ~flush;
    assign stall_cnt = cnt_q;

    always_comb begin
        e_d = '0;
        for (int k = 2; k <= DEPTH; k++) begin
            e_d[k] = e_q[k-1];
        end
        if (id_valid && id_wrt && !stall && !flush) begin
            e_d[1].v    = 1'b1;
            e_d[1].dst  = DST_W'(id_dst);
            e_d[1].load = id_is_load;
        end
        // Flush squashes both the ID instruction and the one just issued.
        if (flush) begin
            e_d[2] = '0;
        end
        cnt_d = cnt_q;
        if (stall && cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_q   <= '0;
            cnt_q <= '0;
        end else begin
            e_q   <= e_d;
            cnt_q <= cnt_d;
        end
    end

endmodule
